text_mem_arbiter: RTL and testbench



---
 rtl/text_pkg.sv | 15 +
 rtl/text_clear_seq.sv | 47 ++++
 rtl/text_mem_arbiter.sv | 172 +++++++++++++++++
 tb/tb_text_mem_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/text_pkg.sv
// Shared constants and state type for the 40x30 text-mode display RAM arbiter.
package text_pkg;
   localparam int COLS   = 40;
   localparam int ROWS   = 30;
   localparam int CELLS  = COLS * ROWS;
   localparam int ADDR_W = 12;
   localparam int DATA_W = 8;
   localparam logic [DATA_W-1:0] FILL_CHAR = 8'h20;

   typedef enum logic [1:0] {
      IDLE,
      CPU_RD,
      CLEAR
   } state_e;
endpackage

// File: rtl/text_clear_seq.sv
// Clear-screen fill counter: walks addresses 0..CELLS-1, one step per advance.
module text_clear_seq
   import text_pkg::*;
(
   input  logic              clk,
   input  logic              clr,
   input  logic              start,
   input  logic              advance,
   output logic [ADDR_W-1:0] addr,
   output logic              last,
   output logic              busy
);

   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              busy_q, busy_d;

   always_comb begin
      cnt_d  = cnt_q;
      busy_d = busy_q;
      if (start) begin
         cnt_d  = '0;
         busy_d = 1'b1;
      end else if (busy_q && advance) begin
         if (last) begin
            cnt_d  = '0;
            busy_d = 1'b0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
      end
   end

   assign addr = cnt_q;
   assign last = (cnt_q == ADDR_W'(CELLS - 1));
   assign busy = busy_q;

endmodule

// File: rtl/text_mem_arbiter.sv
// Display RAM arbiter: renderer > clear fill > CPU on one single-port RAM.
// Optional build macro TEXT_ARB_STALL_CNT_EN adds the stall_cnt output.
module text_mem_arbiter
   import text_pkg::*;
(
   input  logic              clk,
   input  logic              clr,
   input  logic              vid_req,
   input  logic [ADDR_W-1:0] vid_addr,
   output logic [DATA_W-1:0] vid_data,
   output logic              vid_valid,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              clr_scr,
   output logic              clr_busy,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
`ifdef TEXT_ARB_STALL_CNT_EN
   ,
   output logic [15:0]       stall_cnt
`endif
);

   state_e            state_q, state_d;
   logic              vid_valid_q;
   logic              cpu_ack_q, cpu_ack_d;
   logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
   logic              pend_q, pend_d;
   logic              rd_oor_q, rd_oor_d;
   logic              cpu_grant;
   logic              cpu_oor;
   logic              fill_start, fill_adv, fill_last, fill_busy;
   logic [ADDR_W-1:0] fill_addr;

   assign cpu_oor = (cpu_addr >= ADDR_W'(CELLS));

   text_clear_seq u_clear_seq (
      .clk     (clk),
      .clr     (clr),
      .start   (fill_start),
      .advance (fill_adv),
      .addr    (fill_addr),
      .last    (fill_last),
      .busy    (fill_busy)
   );

   // The renderer overrides whatever the state machine picked; reset blanks the port.
   always_comb begin
      state_d     = state_q;
      cpu_ack_d   = 1'b0;
      cpu_rdata_d = cpu_rdata_q;
      pend_d      = pend_q;
      rd_oor_d    = rd_oor_q;
      cpu_grant   = 1'b0;
      fill_start  = 1'b0;
      fill_adv    = 1'b0;
      mem_en      = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;

      if (clr_scr && !pend_q && (state_q != CLEAR)) begin
         pend_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (pend_q) begin
               fill_start = 1'b1;
               pend_d     = 1'b0;
               state_d    = CLEAR;
            end else if (cpu_req && !cpu_ack_q && !vid_req) begin
               cpu_grant = 1'b1;
               if (cpu_we) begin
                  cpu_ack_d = 1'b1;
                  if (!cpu_oor) begin
                     mem_en    = 1'b1;
                     mem_we    = 1'b1;
                     mem_addr  = cpu_addr;
                     mem_wdata = cpu_wdata;
                  end
               end else begin
                  rd_oor_d = cpu_oor;
                  state_d  = CPU_RD;
                  if (!cpu_oor) begin
                     mem_en   = 1'b1;
                     mem_addr = cpu_addr;
                  end
               end
            end
         end
         CPU_RD: begin
            cpu_ack_d   = 1'b1;
            cpu_rdata_d = rd_oor_q ? '0 : mem_rdata;
            state_d     = IDLE;
         end
         CLEAR: begin
            if (!vid_req) begin
               fill_adv  = 1'b1;
               mem_en    = 1'b1;
               mem_we    = 1'b1;
               mem_addr  = fill_addr;
               mem_wdata = FILL_CHAR;
               if (fill_last) begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (vid_req) begin
         mem_en    = 1'b1;
         mem_we    = 1'b0;
         mem_addr  = vid_addr;
         mem_wdata = '0;
      end

      if (clr) begin
         mem_en    = 1'b0;
         mem_we    = 1'b0;
         mem_addr  = '0;
         mem_wdata = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q     <= IDLE;
         vid_valid_q <= 1'b0;
         cpu_ack_q   <= 1'b0;
         cpu_rdata_q <= '0;
         pend_q      <= 1'b0;
         rd_oor_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         vid_valid_q <= vid_req;
         cpu_ack_q   <= cpu_ack_d;
         cpu_rdata_q <= cpu_rdata_d;
         pend_q      <= pend_d;
         rd_oor_q    <= rd_oor_d;
      end
   end

`ifdef TEXT_ARB_STALL_CNT_EN
   logic [15:0] stall_q;

   always_ff @(posedge clk) begin
      if (clr) begin
         stall_q <= '0;
      end else if (cpu_req && !cpu_grant && !cpu_ack_q && (stall_q != 16'hFFFF)) begin
         stall_q <= stall_q + 16'd1;
      end
   end

   assign stall_cnt = stall_q;
`endif

   assign vid_data  = mem_rdata;
   assign vid_valid = vid_valid_q;
   assign cpu_ack   = cpu_ack_q;
   assign cpu_rdata = cpu_rdata_q;
   assign clr_busy  = pend_q | fill_busy;

endmodule

// File: tb/tb_text_mem_arbiter.sv
// Self-checking bench for text_mem_arbiter with a behavioural RAM and shadow-memory model.
// Build with TEXT_ARB_STALL_CNT_EN to also check the stall counter.
module tb_text_mem_arbiter;

   localparam int NCELLS = 40 * 30;

   logic        clk;
   logic        clr;
   logic        vid_req;
   logic [11:0] vid_addr;
   logic [7:0]  vid_data;
   logic        vid_valid;
   logic        cpu_req;
   logic        cpu_we;
   logic [11:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_ack;
   logic [7:0]  cpu_rdata;
   logic        clr_scr;
   logic        clr_busy;
   logic        mem_en;
   logic        mem_we;
   logic [11:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
`ifdef TEXT_ARB_STALL_CNT_EN
   logic [15:0] stall_cnt;
`endif

   int checks = 0;
   int errors = 0;
   int fill_ptr;
   int exp_stall = 0;

   logic [7:0] ram    [4096];
   logic [7:0] shadow [NCELLS];

   text_mem_arbiter dut (
      .clk       (clk),
      .clr       (clr),
      .vid_req   (vid_req),
      .vid_addr  (vid_addr),
      .vid_data  (vid_data),
      .vid_valid (vid_valid),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_ack   (cpu_ack),
      .cpu_rdata (cpu_rdata),
      .clr_scr   (clr_scr),
      .clr_busy  (clr_busy),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
`ifdef TEXT_ARB_STALL_CNT_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single-port RAM with one cycle of read latency.
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         else        mem_rdata     <= ram[mem_addr];
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic vid_read(input logic [11:0] a);
      vid_req  = 1'b1;
      vid_addr = a;
      #1;
      chk("vrd_en", {mem_en, mem_we}, 2'b10);
      chk("vrd_addr", mem_addr, a);
      tick();
      vid_req = 1'b0;
      #1;
      chk("vrd_valid", vid_valid, 1'b1);
      chk("vrd_data", vid_data, shadow[a]);
      tick();
   endtask

   task automatic cpu_write(input logic [11:0] a, input logic [7:0] d, input bit collide,
                            input logic [11:0] va);
      cpu_req   = 1'b1;
      cpu_we    = 1'b1;
      cpu_addr  = a;
      cpu_wdata = d;
      vid_req   = collide;
      vid_addr  = va;
      #1;
      if (collide) begin
         chk("wr_vid_first", {mem_en, mem_we}, 2'b10);
         chk("wr_vid_addr", mem_addr, va);
         tick();
         vid_req = 1'b0;
         #1;
      end
      chk("wr_ack_early", cpu_ack, 1'b0);
      if (a < NCELLS) begin
         chk("wr_en", {mem_en, mem_we}, 2'b11);
         chk("wr_addr", mem_addr, a);
         chk("wr_data", mem_wdata, d);
         shadow[a] = d;
      end else begin
         chk("wr_oor_en", mem_en, 1'b0);
      end
      tick();
      cpu_req = 1'b0;
      #1;
      chk("wr_ack", cpu_ack, 1'b1);
      tick();
   endtask

   task automatic cpu_read(input logic [11:0] a, input bit collide, input logic [11:0] va);
      logic [7:0] exp_d;
      exp_d     = (a < NCELLS) ? shadow[a] : 8'h00;
      cpu_req   = 1'b1;
      cpu_we    = 1'b0;
      cpu_addr  = a;
      cpu_wdata = 8'($urandom);
      vid_req   = collide;
      vid_addr  = va;
      #1;
      if (collide) begin
         chk("rd_vid_first", {mem_en, mem_we}, 2'b10);
         chk("rd_vid_addr", mem_addr, va);
         tick();
         vid_req = 1'b0;
         #1;
         chk("rd_vid_valid", vid_valid, 1'b1);
         chk("rd_vid_data", vid_data, shadow[va]);
      end
      chk("rd_en", {mem_en, mem_we}, (a < NCELLS) ? 2'b10 : 2'b00);
      if (a < NCELLS) chk("rd_addr", mem_addr, a);
      chk("rd_ack_t0", cpu_ack, 1'b0);
      tick();
      #1;
      chk("rd_ack_t1", cpu_ack, 1'b0);
      tick();
      cpu_req = 1'b0;
      #1;
      chk("rd_ack", cpu_ack, 1'b1);
      chk("rd_data", cpu_rdata, exp_d);
      tick();
   endtask

   task automatic start_clear(input bit hold, input logic [11:0] a, input logic [7:0] d);
      clr_scr = 1'b1;
      vid_req = 1'b0;
      cpu_req = 1'b0;
      #1;
      chk("clr_busy_pre", clr_busy, 1'b0);
      tick();
      clr_scr = 1'b0;
      if (hold) begin
         cpu_req   = 1'b1;
         cpu_we    = 1'b1;
         cpu_addr  = a;
         cpu_wdata = d;
      end
      #1;
      chk("clr_busy_pend", clr_busy, 1'b1);
      chk("clr_start_idle", mem_en, 1'b0);
      if (hold) exp_stall++;
   endtask

   task automatic run_fill(input int stop_at, input bit hold);
      int cyc;
      cyc      = 0;
      fill_ptr = 0;
      while (fill_ptr < stop_at) begin
         tick();
         vid_req  = (cyc % 8 == 0);
         vid_addr = 12'($urandom_range(0, NCELLS - 1));
         #1;
         chk("fill_busy", clr_busy, 1'b1);
         chk("fill_no_ack", cpu_ack, 1'b0);
         if (vid_req) begin
            chk("fill_vid_we", {mem_en, mem_we}, 2'b10);
            chk("fill_vid_addr", mem_addr, vid_addr);
         end else begin
            chk("fill_we", {mem_en, mem_we}, 2'b11);
            chk("fill_addr", mem_addr, fill_ptr);
            chk("fill_data", mem_wdata, 8'h20);
            shadow[fill_ptr] = 8'h20;
            fill_ptr++;
         end
         if (hold) exp_stall++;
         cyc++;
      end
   endtask

   initial begin
      logic [11:0] a;
      logic [11:0] va;
      logic [7:0]  d;

      for (int i = 0; i < 4096; i++) ram[i] = 8'($urandom);
      for (int i = 0; i < NCELLS; i++) shadow[i] = ram[i];
      mem_rdata = 8'h00;
      clr       = 1'b1;
      vid_req   = 1'b0;
      vid_addr  = '0;
      cpu_req   = 1'b0;
      cpu_we    = 1'b0;
      cpu_addr  = '0;
      cpu_wdata = '0;
      clr_scr   = 1'b0;
      tick();
      tick();
      #1;
      chk("rst_vid_valid", vid_valid, 1'b0);
      chk("rst_cpu_ack", cpu_ack, 1'b0);
      chk("rst_clr_busy", clr_busy, 1'b0);
      chk("rst_cpu_rdata", cpu_rdata, 8'h00);
      chk("rst_mem_en", mem_en, 1'b0);
`ifdef TEXT_ARB_STALL_CNT_EN
      chk("rst_stall", stall_cnt, 16'd0);
`endif
      clr = 1'b0;
      tick();

      $display("[TB] directed CPU write/read");
      cpu_write(12'd41, 8'h41, 1'b0, 12'd0);
      vid_read(12'd41);
      chk("cell41_const", shadow[41], 8'h41);
      cpu_read(12'd41, 1'b1, 12'd0);
      cpu_write(12'd1200, 8'h5A, 1'b0, 12'd0);
      cpu_read(12'd4095, 1'b0, 12'd0);

      $display("[TB] randomized CPU traffic");
      for (int n = 0; n < 60; n++) begin
         a  = ($urandom_range(0, 9) == 0) ? 12'($urandom_range(NCELLS, 4095))
                                          : 12'($urandom_range(0, NCELLS - 1));
         va = 12'($urandom_range(0, NCELLS - 1));
         d  = 8'($urandom);
         if ($urandom_range(0, 1) == 1) cpu_write(a, d, $urandom_range(0, 3) == 0, va);
         else                           cpu_read(a, $urandom_range(0, 3) == 0, va);
      end
      for (int n = 0; n < 8; n++) vid_read(12'($urandom_range(0, NCELLS - 1)));

      $display("[TB] clear aborted by reset at cell 600");
      start_clear(1'b0, 12'd0, 8'h00);
      run_fill(600, 1'b0);
      tick();
      vid_req = 1'b0;
      clr     = 1'b1;
      #1;
      chk("abort_no_write", mem_en, 1'b0);
      tick();
      clr = 1'b0;
      #1;
      chk("abort_busy", clr_busy, 1'b0);
      chk("abort_idle_en", mem_en, 1'b0);
      tick();
      #1;
      chk("abort_still_idle", mem_en, 1'b0);
      chk("abort_busy2", clr_busy, 1'b0);
      tick();
      cpu_write(12'd5, 8'hA5, 1'b0, 12'd0);
      vid_read(12'd5);
      vid_read(12'd599);

      $display("[TB] full clear with CPU request held");
      clr = 1'b1;
      tick();
      clr       = 1'b0;
      exp_stall = 0;
      tick();
      a = 12'($urandom_range(0, NCELLS - 1));
      d = 8'($urandom);
      start_clear(1'b1, a, d);
      run_fill(NCELLS, 1'b1);
      tick();
      vid_req = 1'b0;
      #1;
      chk("post_busy", clr_busy, 1'b0);
      chk("post_cpu_we", {mem_en, mem_we}, 2'b11);
      chk("post_cpu_addr", mem_addr, a);
      chk("post_cpu_data", mem_wdata, d);
      shadow[a] = d;
      tick();
      cpu_req = 1'b0;
      #1;
      chk("post_cpu_ack", cpu_ack, 1'b1);
`ifdef TEXT_ARB_STALL_CNT_EN
      chk("stall_cnt", stall_cnt, exp_stall);
`endif
      tick();

      $display("[TB] read back every cell through the renderer port");
      for (int i = 0; i <= NCELLS; i++) begin
         vid_req  = (i < NCELLS);
         vid_addr = (i < NCELLS) ? 12'(i) : 12'd0;
         #1;
         if (i > 0) begin
            chk("scan_valid", vid_valid, 1'b1);
            chk("scan_data", vid_data, shadow[i-1]);
         end
         tick();
      end
      vid_req = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
